button_shaper_multi: RTL and testbench

Multi-channel successor to the single-button shaper. Each of `N_BTN` raw push-button inputs is synchronised, debounced, and turned into single-cycle press pulses. An optional per-channel auto-repeat mode emits further pulses while the button stays held. Sits between the board push-buttons and the control FSMs that consume one-cycle "press" events.

---
 rtl/button_shaper_pkg.sv | 15 +
 rtl/button_shaper_chan.sv | 113 +++++++++++
 rtl/button_shaper_multi.sv | 35 +++
 tb/tb_button_shaper_multi.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/button_shaper_pkg.sv
// Shared FSM encoding and default timing for the multi-channel button shaper.
package button_shaper_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PRESS  = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;
    localparam logic [1:0] S_REPEAT = 2'd3;

    localparam int DEF_N_BTN        = 4;
    localparam int DEF_DEBOUNCE_CYC = 4;
    localparam int DEF_REPEAT_DLY   = 16;
    localparam int DEF_REPEAT_PER   = 4;
    localparam int DEF_CNT_W        = 8;

endpackage

// File: rtl/button_shaper_chan.sv
// One button channel: 2-flop synchroniser, debouncer, press/auto-repeat FSM.
module button_shaper_chan
    import button_shaper_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DLY   = DEF_REPEAT_DLY,
    parameter int REPEAT_PER   = DEF_REPEAT_PER,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    input  logic repeat_en,
    output logic pulse,
    output logic held
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PER - 1);

    logic             s1;
    logic             s2;
    logic             deb;
    logic [CNT_W-1:0] dcnt;
    logic [CNT_W-1:0] rcnt;
    logic [1:0]       state;
    logic             deb_fall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= button;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb  <= 1'b0;
            dcnt <= '0;
        end else if (s2 == deb) begin
            dcnt <= '0;
        end else if (dcnt == DEB_LAST) begin
            deb  <= s2;
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

    // A release accepted this cycle overrides any repeat falling due on the same edge.
    always_comb deb_fall = deb && !s2 && (dcnt == DEB_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            rcnt  <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (!deb || deb_fall) begin
                state <= S_IDLE;
                rcnt  <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_PRESS;
                        pulse <= 1'b1;
                    end
                    S_PRESS: begin
                        state <= S_HOLD;
                        rcnt  <= CNT_W'(1);
                    end
                    S_HOLD: begin
                        if (repeat_en) begin
                            if (rcnt == DLY_LAST) begin
                                state <= S_REPEAT;
                                rcnt  <= '0;
                                pulse <= 1'b1;
                            end else begin
                                rcnt <= sat_inc(rcnt);
                            end
                        end
                    end
                    S_REPEAT: begin
                        if (!repeat_en) begin
                            state <= S_HOLD;
                        end else if (rcnt == PER_LAST) begin
                            rcnt  <= '0;
                            pulse <= 1'b1;
                        end else begin
                            rcnt <= sat_inc(rcnt);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        rcnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign held = deb;

endmodule

// File: rtl/button_shaper_multi.sv
// N_BTN independent button shaper channels side by side.
module button_shaper_multi
    import button_shaper_pkg::*;
#(
    parameter int N_BTN        = DEF_N_BTN,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DLY   = DEF_REPEAT_DLY,
    parameter int REPEAT_PER   = DEF_REPEAT_PER,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [N_BTN-1:0] buttonInput,
    input  logic [N_BTN-1:0] repeatEn,
    output logic [N_BTN-1:0] buttonOutput,
    output logic [N_BTN-1:0] buttonHeld
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        button_shaper_chan #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .REPEAT_DLY  (REPEAT_DLY),
            .REPEAT_PER  (REPEAT_PER),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk      (Clk),
            .rst_n    (Rst),
            .button   (buttonInput[i]),
            .repeat_en(repeatEn[i]),
            .pulse    (buttonOutput[i]),
            .held     (buttonHeld[i])
        );
    end

endmodule

// File: tb/tb_button_shaper_multi.sv
// Scoreboard bench: stimulus queues expected pulse edges per channel, a negedge monitor pops and compares.
module tb_button_shaper_multi;

    localparam int N = 4;

    logic         Clk = 1'b0;
    logic         Rst = 1'b0;
    logic [N-1:0] buttonInput = '0;
    logic [N-1:0] repeatEn = '0;
    logic [N-1:0] buttonOutput;
    logic [N-1:0] buttonHeld;

    int checks = 0;
    int failures = 0;
    int edge_n = 0;
    int exp_q[N][$];
    int base;

    button_shaper_multi #(
        .N_BTN       (N),
        .DEBOUNCE_CYC(4),
        .REPEAT_DLY  (16),
        .REPEAT_PER  (4),
        .CNT_W       (8)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .buttonInput (buttonInput),
        .repeatEn    (repeatEn),
        .buttonOutput(buttonOutput),
        .buttonHeld  (buttonHeld)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) edge_n <= edge_n + 1;

    // Monitor: every observed pulse must match the head of its channel's queue.
    always @(negedge Clk) begin
        int e;
        if (Rst) begin
            for (int ch = 0; ch < N; ch++) begin
                if (buttonOutput[ch]) begin
                    checks++;
                    if (exp_q[ch].size() == 0) begin
                        failures++;
                        $display("FAIL pulse_ch%0d: pulse at edge %0d, expected none", ch, edge_n);
                    end else begin
                        e = exp_q[ch].pop_front();
                        if (e != edge_n) begin
                            failures++;
                            $display("FAIL pulse_ch%0d: pulse at edge %0d, expected edge %0d", ch, edge_n, e);
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %b expected %b at edge %0d", name, got, want, edge_n);
        end
    endtask

    initial begin
        // Reset state
        tick(3);
        check("reset_out", buttonOutput, '0);
        check("reset_held", buttonHeld, '0);
        Rst = 1'b1;
        tick(3);
        check("idle_held", buttonHeld, '0);

        // Ch0 clean press, 10 cycles, no repeat
        base = edge_n + 1;
        buttonInput[0] = 1'b1;
        exp_q[0].push_back(base + 6);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("clean_held", buttonHeld, N'(i >= 5 && i <= 14));
            if (i == 9) buttonInput[0] = 1'b0;
        end
        tick(5);

        // Ch1 bounce: 1,1,0 then stable high from relative edge 3
        base = edge_n + 1;
        exp_q[1].push_back(base + 9);
        for (int r = 0; r < 30; r++) begin
            buttonInput[1] = (r != 2) && (r < 15);
            tick(1);
            if (r == 7) check("bounce_held_lo", buttonHeld, '0);
            if (r == 8) check("bounce_held_hi", buttonHeld, 4'b0010);
        end
        check("bounce_released", buttonHeld, '0);

        // Ch2 auto-repeat; release timed so a repeat falls due on the release edge
        repeatEn[2] = 1'b1;
        base = edge_n + 1;
        foreach (exp_q[0][k]) begin end
        exp_q[2].push_back(base + 6);
        exp_q[2].push_back(base + 22);
        exp_q[2].push_back(base + 26);
        exp_q[2].push_back(base + 30);
        exp_q[2].push_back(base + 34);
        exp_q[2].push_back(base + 38);
        for (int r = 0; r < 60; r++) begin
            buttonInput[2] = (r < 37);
            tick(1);
        end
        repeatEn[2] = 1'b0;

        // Ch3 repeatEn dropped for 5 cycles starting at relative edge 24
        repeatEn[3] = 1'b1;
        base = edge_n + 1;
        exp_q[3].push_back(base + 6);
        exp_q[3].push_back(base + 22);
        exp_q[3].push_back(base + 43);
        exp_q[3].push_back(base + 47);
        exp_q[3].push_back(base + 51);
        for (int r = 0; r < 70; r++) begin
            buttonInput[3] = (r < 48);
            repeatEn[3] = !(r >= 24 && r <= 28);
            tick(1);
        end
        repeatEn[3] = 1'b0;

        // All channels pressed together, staggered release
        base = edge_n + 1;
        for (int ch = 0; ch < N; ch++) exp_q[ch].push_back(base + 6);
        for (int r = 0; r < 40; r++) begin
            for (int ch = 0; ch < N; ch++) buttonInput[ch] = (r < 8 + 3 * ch);
            tick(1);
            if (r == 6)  check("multi_held_all", buttonHeld, 4'b1111);
            if (r == 14) check("multi_held_r14", buttonHeld, 4'b1110);
            if (r == 20) check("multi_held_r20", buttonHeld, 4'b1000);
            if (r == 23) check("multi_held_r23", buttonHeld, 4'b0000);
        end

        // Reset mid-repeat with ch2 held, then fresh press after reset release
        repeatEn[2] = 1'b1;
        base = edge_n + 1;
        buttonInput[2] = 1'b1;
        exp_q[2].push_back(base + 6);
        exp_q[2].push_back(base + 22);
        exp_q[2].push_back(base + 26);
        tick(27);
        #2 Rst = 1'b0;
        #1;
        check("rst_mid_out", buttonOutput, '0);
        check("rst_mid_held", buttonHeld, '0);
        tick(2);
        check("rst_hold_held", buttonHeld, '0);
        tick(1);
        Rst = 1'b1;
        base = edge_n + 1;
        exp_q[2].push_back(base + 6);
        for (int r = 0; r < 30; r++) begin
            buttonInput[2] = (r < 15);
            tick(1);
            if (r == 5) check("rst_fresh_held", buttonHeld, 4'b0100);
        end
        repeatEn[2] = 1'b0;
        tick(5);

        for (int ch = 0; ch < N; ch++) begin
            checks++;
            if (exp_q[ch].size() != 0) begin
                failures++;
                $display("FAIL missing_ch%0d: %0d expected pulses never seen, next at edge %0d",
                         ch, exp_q[ch].size(), exp_q[ch][0]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
